// File: rtl/instruction_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue and the decode stages
// that consume its byte window.
//
// Contents:
//   QUEUE_BYTES   - default byte capacity of the circular prefetch store
//   WINDOW_BYTES  - default number of bytes presented to the decoder per cycle
//   RESET_VECTOR  - linear address fetched first after reset
//   byte_window_t - unpacked byte window, element 0 = next unconsumed byte
//   window_fill() - number of valid window bytes for a given queue occupancy
package instruction_prefetch_queue_pkg;

  localparam int unsigned QUEUE_BYTES  = 32;
  localparam int unsigned WINDOW_BYTES = 16;
  localparam logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0;

  typedef logic [7:0] byte_window_t [WINDOW_BYTES];

  // Valid bytes the decoder can see: the occupancy, capped at the window size.
  function automatic int unsigned window_fill(input int unsigned count,
                                              input int unsigned window);
    return (count > window) ? window : count;
  endfunction

endpackage

// File: rtl/prefetch_window_align.sv
// Extracts the decoder byte window from the circular prefetch store.
//
// The window is a modular rotation of the store starting at the read pointer.
// Bytes at or beyond the valid count are forced to zero so the decoder never
// sees stale store contents.
//
// Ports:
//   i_store    - whole circular byte store
//   i_rd       - read pointer (index of the next unconsumed byte)
//   i_avail    - number of valid bytes in the window
//   o_window   - byte window, element 0 = store[i_rd]
module prefetch_window_align #(
  parameter int unsigned QUEUE_BYTES  = 32,
  parameter int unsigned WINDOW_BYTES = 16
) (
  input  logic [7:0]                          i_store [QUEUE_BYTES],
  input  logic [$clog2(QUEUE_BYTES)-1:0]      i_rd,
  input  logic [$clog2(WINDOW_BYTES+1)-1:0]   i_avail,
  output logic [7:0]                          o_window [WINDOW_BYTES]
);

  localparam int unsigned PtrW = $clog2(QUEUE_BYTES);

  always_comb begin
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      o_window[k] = 8'h00;
      if (k < int'(i_avail)) begin
        // Pointer arithmetic wraps naturally at the store size (power of two).
        o_window[k] = i_store[PtrW'(i_rd + PtrW'(k))];
      end
    end
  end

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue.
//
// Fetches dwords from a linear address stream into a circular byte store and
// presents the oldest unconsumed bytes to the decoder as a byte window. A flush
// restarts fetch at an arbitrary byte address; the leading bytes of the first
// dword below that address are skipped. Consuming more bytes than the window
// holds is refused and latches a sticky error until the next flush or reset.
//
// Ports:
//   i_clock            - sole clock, all state changes on the rising edge
//   i_reset            - synchronous active-high reset, priority over flush
//   i_flush            - drop queued bytes, restart fetch at i_flush_address
//   i_flush_address    - linear byte address of the next instruction
//   o_fetch_request    - queue has room for one more dword
//   o_fetch_address    - dword-aligned address of the requested dword
//   i_fetch_valid      - i_fetch_data valid this cycle
//   i_fetch_data       - fetched dword, little-endian
//   o_instruction      - decoder byte window, element 0 = next unconsumed byte
//   o_bytes_available  - valid bytes in the window
//   i_consume_bytes    - bytes retired by the decoder this cycle
//   o_error            - sticky consume-overrun flag
module instruction_prefetch_queue #(
  parameter int unsigned QUEUE_BYTES  = instruction_prefetch_queue_pkg::QUEUE_BYTES,
  parameter int unsigned WINDOW_BYTES = instruction_prefetch_queue_pkg::WINDOW_BYTES
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_flush,
  input  logic [31:0]                         i_flush_address,
  output logic                                o_fetch_request,
  output logic [31:0]                         o_fetch_address,
  input  logic                                i_fetch_valid,
  input  logic [31:0]                         i_fetch_data,
  output logic [7:0]                          o_instruction [WINDOW_BYTES],
  output logic [$clog2(WINDOW_BYTES+1)-1:0]   o_bytes_available,
  input  logic [$clog2(WINDOW_BYTES+1)-1:0]   i_consume_bytes,
  output logic                                o_error
);

  import instruction_prefetch_queue_pkg::RESET_VECTOR;
  import instruction_prefetch_queue_pkg::window_fill;

  localparam int unsigned PtrW   = $clog2(QUEUE_BYTES);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned AvailW = $clog2(WINDOW_BYTES + 1);

  // Architectural state
  logic [PtrW-1:0] rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [1:0]      skip_q, skip_d;
  logic            error_q, error_d;
  logic [7:0]      store_q [QUEUE_BYTES];
  logic [7:0]      store_d [QUEUE_BYTES];

  // Per-cycle decode
  logic [AvailW-1:0] avail;
  logic              fetch_request;
  logic              accept;
  logic              overrun;
  logic [CntW-1:0]   consume_cnt;
  logic [CntW-1:0]   written_cnt;
  logic [PtrW-1:0]   wr_ptr;

  always_comb begin
    avail         = AvailW'(window_fill(int'(count_q), WINDOW_BYTES));
    // Room for a full dword is required even when skip will discard some bytes.
    fetch_request = (count_q <= CntW'(QUEUE_BYTES - 4)) && !i_flush;
    accept        = i_fetch_valid && fetch_request;
    overrun       = i_consume_bytes > avail;
    consume_cnt   = overrun ? '0 : CntW'(i_consume_bytes);
    written_cnt   = accept ? (CntW'(4) - CntW'(skip_q)) : '0;
    wr_ptr        = rd_q + PtrW'(count_q);
  end

  // Store update: bytes skip..3 of an accepted dword land contiguously at the
  // write position. Writes during reset are harmless because count is cleared.
  always_comb begin
    store_d = store_q;
    if (accept) begin
      for (int j = 0; j < 4; j++) begin
        if (j >= int'(skip_q)) begin
          store_d[PtrW'(wr_ptr + PtrW'(j) - PtrW'(skip_q))] = i_fetch_data[8*j +: 8];
        end
      end
    end
  end

  // Control next state; flush overrides consume and fetch in the same cycle.
  always_comb begin
    rd_d         = rd_q + PtrW'(consume_cnt);
    count_d      = count_q - consume_cnt + written_cnt;
    fetch_addr_d = accept ? (fetch_addr_q + 32'd4) : fetch_addr_q;
    skip_d       = accept ? 2'd0 : skip_q;
    error_d      = error_q | overrun;
    if (i_flush) begin
      rd_d         = '0;
      count_d      = '0;
      fetch_addr_d = {i_flush_address[31:2], 2'b00};
      skip_d       = i_flush_address[1:0];
      error_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_q         <= '0;
      count_q      <= '0;
      fetch_addr_q <= RESET_VECTOR;
      skip_q       <= 2'd0;
      error_q      <= 1'b0;
    end else begin
      rd_q         <= rd_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      skip_q       <= skip_d;
      error_q      <= error_d;
    end
  end

  // Data store carries no reset; unoccupied entries are masked by the window.
  always_ff @(posedge i_clock) begin
    store_q <= store_d;
  end

  prefetch_window_align #(
    .QUEUE_BYTES  (QUEUE_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_window_align (
    .i_store  (store_q),
    .i_rd     (rd_q),
    .i_avail  (avail),
    .o_window (o_instruction)
  );

  assign o_fetch_request   = fetch_request;
  assign o_fetch_address   = fetch_addr_q;
  assign o_bytes_available = avail;
  assign o_error           = error_q;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed scenarios followed by a
// randomized run, all checked against a byte-stream reference model.
module tb_instruction_prefetch_queue;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_address = '0;
  logic        o_fetch_request;
  logic [31:0] o_fetch_address;
  logic        i_fetch_valid = 1'b0;
  logic [31:0] i_fetch_data = '0;
  logic [7:0]  o_instruction [16];
  logic [4:0]  o_bytes_available;
  logic [4:0]  i_consume_bytes = '0;
  logic        o_error;

  always #5 i_clock = ~i_clock;

  instruction_prefetch_queue dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_flush           (i_flush),
    .i_flush_address   (i_flush_address),
    .o_fetch_request   (o_fetch_request),
    .o_fetch_address   (o_fetch_address),
    .i_fetch_valid     (i_fetch_valid),
    .i_fetch_data      (i_fetch_data),
    .o_instruction     (o_instruction),
    .o_bytes_available (o_bytes_available),
    .i_consume_bytes   (i_consume_bytes),
    .o_error           (o_error)
  );

  // Reference model: the queue is just the ordered stream of fetched bytes.
  logic [7:0]  mq [$];
  logic [31:0] m_addr = 32'hFFFF_FFF0;
  logic [1:0]  m_skip = 2'd0;
  logic        m_err = 1'b0;
  int          m_accepts = 0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic fl);
    int          size;
    int          avail;
    logic [127:0] exp_w;
    logic [127:0] obs_w;
    size  = mq.size();
    avail = (size < 16) ? size : 16;
    exp_w = '0;
    obs_w = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < avail) exp_w[8*k +: 8] = mq[k];
      obs_w[8*k +: 8] = o_instruction[k];
    end
    check("request", 128'(o_fetch_request), 128'((size <= 28) && !fl));
    check("address", 128'(o_fetch_address), 128'(m_addr));
    check("avail",   128'(o_bytes_available), 128'(avail));
    check("window",  obs_w, exp_w);
    check("error",   128'(o_error), 128'(m_err));
  endtask

  task automatic model_update(input logic rst, input logic fl, input logic [31:0] fa,
                              input logic fv, input logic [31:0] fd, input int cons);
    int size;
    int avail;
    bit req;
    size  = mq.size();
    avail = (size < 16) ? size : 16;
    req   = (size <= 28) && !fl;
    if (rst) begin
      mq.delete();
      m_addr = 32'hFFFF_FFF0;
      m_skip = 2'd0;
      m_err  = 1'b0;
    end else if (fl) begin
      mq.delete();
      m_addr = fa & ~32'd3;
      m_skip = fa[1:0];
      m_err  = 1'b0;
    end else begin
      if (cons > avail) m_err = 1'b1;
      else repeat (cons) void'(mq.pop_front());
      if (fv && req) begin
        for (int j = int'(m_skip); j < 4; j++) mq.push_back(fd[8*j +: 8]);
        m_addr = m_addr + 32'd4;
        m_skip = 2'd0;
        m_accepts++;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic rst, input logic fl, input logic [31:0] fa,
                      input logic fv, input logic [31:0] fd, input int cons,
                      input bit do_chk);
    @(negedge i_clock);
    i_reset         = rst;
    i_flush         = fl;
    i_flush_address = fa;
    i_fetch_valid   = fv;
    i_fetch_data    = fd;
    i_consume_bytes = 5'(cons);
    #1;
    if (do_chk) check_outputs(fl);
    model_update(rst, fl, fa, fv, fd, cons);
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1);
  endtask

  task automatic feed(input logic [31:0] d, input int cons);
    step(1'b0, 1'b0, 32'h0, 1'b1, d, cons, 1'b1);
  endtask

  task automatic flush_to(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b1, 32'hDEAD_BEEF, 0, 1'b1);
  endtask

  initial begin
    int cycles;
    int avail;

    // Reset with junk fetch and consume in flight.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 3, 1'b0);
    check("rst_addr",  128'(o_fetch_address), 128'(32'hFFFF_FFF0));
    check("rst_req",   128'(o_fetch_request), 128'(1));
    check("rst_avail", 128'(o_bytes_available), 128'(0));
    check("rst_err",   128'(o_error), 128'(0));
    idle();

    // Two dwords from the reset vector.
    feed(32'h0403_0201, 0);
    check("seq_addr1", 128'(o_fetch_address), 128'(32'hFFFF_FFF4));
    feed(32'h0807_0605, 0);
    check("seq_avail", 128'(o_bytes_available), 128'(8));
    check("seq_w0",    128'(o_instruction[0]), 128'(8'h01));
    check("seq_w7",    128'(o_instruction[7]), 128'(8'h08));
    check("seq_w8",    128'(o_instruction[8]), 128'(8'h00));
    idle();

    // Flush to a misaligned address: leading three bytes skipped.
    flush_to(32'h0000_1003);
    check("fl_addr", 128'(o_fetch_address), 128'(32'h0000_1000));
    feed(32'hDDCC_BBAA, 0);
    check("fl_w0",    128'(o_instruction[0]), 128'(8'hDD));
    check("fl_avail", 128'(o_bytes_available), 128'(1));

    // Fill until the request drops, including a dword offered while full.
    for (int n = 0; n < 8; n++) feed(32'h1111_1111 * (n + 1), 0);
    check("full_req", 128'(o_fetch_request), 128'(0));
    feed(32'h5555_AAAA, 4);
    check("drain_req", 128'(o_fetch_request), 128'(1));
    idle();

    // Count 6, consume 3 while a dword lands.
    flush_to(32'h0000_2002);
    feed(32'h4433_2211, 0);
    feed(32'h8877_6655, 0);
    check("c6_avail", 128'(o_bytes_available), 128'(6));
    feed(32'hCCBB_AA99, 3);
    check("c7_avail", 128'(o_bytes_available), 128'(7));
    check("c7_w0",    128'(o_instruction[0]), 128'(8'h66));
    check("c7_w6",    128'(o_instruction[6]), 128'(8'hCC));

    // Overrun: sticky error until flush.
    flush_to(32'h0000_3002);
    feed(32'h2222_1111, 0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 5, 1'b1);
    check("ovr_err",   128'(o_error), 128'(1));
    check("ovr_avail", 128'(o_bytes_available), 128'(2));
    idle();
    idle();
    flush_to(32'h0000_4000);
    check("ovr_clr", 128'(o_error), 128'(0));

    // Reset mid-operation discards queued bytes.
    feed(32'h0BAD_F00D, 0);
    step(1'b1, 1'b1, 32'h0000_5000, 1'b1, 32'h1357_9BDF, 2, 1'b1);
    check("mrst_avail", 128'(o_bytes_available), 128'(0));
    check("mrst_addr",  128'(o_fetch_address), 128'(32'hFFFF_FFF0));
    idle();

    // Random stream with legal consumes, well past pointer wrap.
    flush_to(32'($urandom));
    m_accepts = 0;
    cycles    = 0;
    while (m_accepts < 100 && cycles < 3000) begin
      avail = (mq.size() < 16) ? mq.size() : 16;
      step(1'b0, 1'b0, 32'h0, ($urandom_range(0, 3) != 0), $urandom,
           $urandom_range(0, avail), 1'b1);
      cycles++;
    end
    check("rand_budget", 128'(m_accepts >= 100), 128'(1));
    while (mq.size() > 0 && cycles < 3200) begin
      avail = (mq.size() < 16) ? mq.size() : 16;
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, $urandom_range(1, avail), 1'b1);
      cycles++;
    end
    check("rand_drained", 128'(o_bytes_available), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
